// File: rtl/sn7402.sv
// Quad 2-input NOR gate (7402 pinout) with supply checking and optional
// per-gate rising-edge statistics, compiled in when SN7402_STATS_EN is defined.
module sn7402 (
  output logic        P1,
  input  logic        P2,
  input  logic        P3,
  output logic        P4,
  input  logic        P5,
  input  logic        P6,
  input  logic        P7,
  input  logic        P8,
  input  logic        P9,
  output logic        P10,
  input  logic        P11,
  input  logic        P12,
  output logic        P13,
  input  logic        P14,
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  cnt_sel,
  output logic [15:0] cnt,
  output logic        pwr_fault
);

  logic       supply_ok;
  logic [3:0] gate_y;
  logic       pwr_fault_q;
  logic       pwr_fault_d;

  // Case-equality so a floating or unknown supply pin counts as invalid.
  assign supply_ok = (P14 === 1'b1) && (P7 === 1'b0);

  // The NOR operator already yields 0 when either input is 1, else X on X/Z.
  assign gate_y[0] = ~(P2 | P3);
  assign gate_y[1] = ~(P5 | P6);
  assign gate_y[2] = ~(P8 | P9);
  assign gate_y[3] = ~(P11 | P12);

  assign P1  = supply_ok ? gate_y[0] : 1'bz;
  assign P4  = supply_ok ? gate_y[1] : 1'bz;
  assign P10 = supply_ok ? gate_y[2] : 1'bz;
  assign P13 = supply_ok ? gate_y[3] : 1'bz;

  always_comb begin
    pwr_fault_d = ~supply_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwr_fault_q <= 1'b0;
    end else begin
      pwr_fault_q <= pwr_fault_d;
    end
  end

  assign pwr_fault = pwr_fault_q;

`ifdef SN7402_STATS_EN
  logic [3:0]  gate_hi;
  logic [3:0]  rise;
  logic [3:0]  prev_q;
  logic [3:0]  prev_d;
  logic        armed_q;
  logic        armed_d;
  logic [15:0] cnt_a_q, cnt_b_q, cnt_c_q, cnt_d_q;
  logic [15:0] cnt_a_d, cnt_b_d, cnt_c_d, cnt_d_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] val, input logic en);
    sat_inc = (en && (val != 16'hFFFF)) ? val + 16'd1 : val;
  endfunction

  // Only a solid 1 on a powered gate counts as high; X/Z samples become 0.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      gate_hi[i] = supply_ok && (gate_y[i] === 1'b1);
    end
    rise    = gate_hi & ~prev_q & {4{armed_q}};
    prev_d  = gate_hi;
    armed_d = 1'b1;
    cnt_a_d = sat_inc(cnt_a_q, rise[0]);
    cnt_b_d = sat_inc(cnt_b_q, rise[1]);
    cnt_c_d = sat_inc(cnt_c_q, rise[2]);
    cnt_d_d = sat_inc(cnt_d_q, rise[3]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= 4'b0000;
      armed_q <= 1'b0;
      cnt_a_q <= 16'h0000;
      cnt_b_q <= 16'h0000;
      cnt_c_q <= 16'h0000;
      cnt_d_q <= 16'h0000;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      cnt_c_q <= cnt_c_d;
      cnt_d_q <= cnt_d_d;
    end
  end

  always_comb begin
    cnt = 16'h0000;
    case (cnt_sel)
      2'd0:    cnt = cnt_a_q;
      2'd1:    cnt = cnt_b_q;
      2'd2:    cnt = cnt_c_q;
      default: cnt = cnt_d_q;
    endcase
  end
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sn7402.sv
// Directed bench for sn7402: truth table, X handling, supply fault and,
// when SN7402_STATS_EN is defined, the rising-edge counters.
module tb_sn7402;

`ifdef SN7402_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p2, p3, p5, p6, p7, p8, p9, p11, p12, p14;
  logic [1:0]  cnt_sel;
  wire         p1, p4, p10, p13;
  wire  [15:0] cnt;
  wire         pwr_fault;

  int checks = 0;
  int errors = 0;
  bit four_state;

  sn7402 dut (
    .P1(p1), .P2(p2), .P3(p3), .P4(p4), .P5(p5), .P6(p6), .P7(p7),
    .P8(p8), .P9(p9), .P10(p10), .P11(p11), .P12(p12), .P13(p13), .P14(p14),
    .clk(clk), .rst(rst), .cnt_sel(cnt_sel), .cnt(cnt), .pwr_fault(pwr_fault)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_gate(input int g, input logic a, input logic b);
    case (g)
      0:       begin p2  = a; p3  = b; end
      1:       begin p5  = a; p6  = b; end
      2:       begin p8  = a; p9  = b; end
      default: begin p11 = a; p12 = b; end
    endcase
  endtask

  function automatic logic get_out(input int g);
    case (g)
      0:       get_out = p1;
      1:       get_out = p4;
      2:       get_out = p10;
      default: get_out = p13;
    endcase
  endfunction

  task automatic apply_reset;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    p14 = 1'b0;
    tick();
    checks++;
    if (pwr_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_pwr_fault got %b want 0", pwr_fault);
    end
    checks++;
    if (cnt !== 16'h0000) begin
      errors++;
      $display("FAIL reset_cnt got %h want 0000", cnt);
    end
    p14 = 1'b1;
    #1;
  endtask

  task automatic test_truth;
    for (int g = 0; g < 4; g++) begin
      for (int v = 0; v < 4; v++) begin
        set_gate(g, v[1], v[0]);
        #1;
        checks++;
        if (get_out(g) !== (v == 0)) begin
          errors++;
          $display("FAIL truth_g%0d_in%0d%0d got %b want %b", g, v[1], v[0], get_out(g), (v == 0));
        end
      end
      set_gate(g, 1'b1, 1'b1);
    end
  endtask

  task automatic test_xprop;
    p2 = 1'b1; p3 = 1'bx;
    #1;
    checks++;
    if (p1 !== 1'b0) begin
      errors++;
      $display("FAIL xprop_dominant got %b want 0", p1);
    end
    p2 = 1'b0;
    #1;
    if (four_state) begin
      checks++;
      if (p1 !== 1'bx) begin
        errors++;
        $display("FAIL xprop_unknown got %b want x", p1);
      end
    end
    p2 = 1'b1; p3 = 1'b1;
    #1;
  endtask

  task automatic test_supply;
    p14 = 1'b0;
    #1;
    if (four_state) begin
      for (int g = 0; g < 4; g++) begin
        checks++;
        if (get_out(g) !== 1'bz) begin
          errors++;
          $display("FAIL supply_hiz_g%0d got %b want z", g, get_out(g));
        end
      end
    end
    checks++;
    if (pwr_fault !== 1'b0) begin
      errors++;
      $display("FAIL supply_fault_before_edge got %b want 0", pwr_fault);
    end
    tick();
    checks++;
    if (pwr_fault !== 1'b1) begin
      errors++;
      $display("FAIL supply_vcc_fault got %b want 1", pwr_fault);
    end
    p14 = 1'b1;
    tick();
    checks++;
    if (pwr_fault !== 1'b0) begin
      errors++;
      $display("FAIL supply_vcc_clear got %b want 0", pwr_fault);
    end
    p7 = 1'b1;
    tick();
    checks++;
    if (pwr_fault !== 1'b1) begin
      errors++;
      $display("FAIL supply_gnd_fault got %b want 1", pwr_fault);
    end
    p7 = 1'b0;
    tick();
    checks++;
    if (pwr_fault !== 1'b0) begin
      errors++;
      $display("FAIL supply_gnd_clear got %b want 0", pwr_fault);
    end
  endtask

  task automatic test_armed;
    cnt_sel = 2'd0;
    set_gate(0, 1'b0, 1'b0);
    apply_reset();
    tick();
    checks++;
    if (cnt !== 16'h0000) begin
      errors++;
      $display("FAIL armed_first_edge got %h want 0000", cnt);
    end
    set_gate(0, 1'b1, 1'b1);
    tick();
    set_gate(0, 1'b0, 1'b0);
    tick();
    checks++;
    if (cnt !== (STATS ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL armed_then_count got %h want %h", cnt, (STATS ? 16'd1 : 16'd0));
    end
    set_gate(0, 1'b1, 1'b1);
  endtask

  task automatic test_count;
    for (int g = 0; g < 4; g++) set_gate(g, 1'b1, 1'b1);
    apply_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      set_gate(0, 1'b0, 1'b0);
      tick();
      set_gate(0, 1'b1, 1'b1);
      tick();
    end
    cnt_sel = 2'd0;
    #1;
    checks++;
    if (cnt !== (STATS ? 16'd5 : 16'd0)) begin
      errors++;
      $display("FAIL count_a got %h want %h", cnt, (STATS ? 16'd5 : 16'd0));
    end
    for (int s = 1; s < 4; s++) begin
      cnt_sel = s[1:0];
      #1;
      checks++;
      if (cnt !== 16'h0000) begin
        errors++;
        $display("FAIL count_sel%0d got %h want 0000", s, cnt);
      end
    end
    // Gate B two rising edges, then cnt_sel switches with no clock in between.
    for (int i = 0; i < 2; i++) begin
      set_gate(1, 1'b0, 1'b0);
      tick();
      set_gate(1, 1'b1, 1'b1);
      tick();
    end
    cnt_sel = 2'd1;
    #1;
    checks++;
    if (cnt !== (STATS ? 16'd2 : 16'd0)) begin
      errors++;
      $display("FAIL count_b got %h want %h", cnt, (STATS ? 16'd2 : 16'd0));
    end
    cnt_sel = 2'd0;
    #1;
    checks++;
    if (cnt !== (STATS ? 16'd5 : 16'd0)) begin
      errors++;
      $display("FAIL count_sel_back got %h want %h", cnt, (STATS ? 16'd5 : 16'd0));
    end
  endtask

  task automatic test_no_count_unpowered;
    cnt_sel = 2'd0;
    p14 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_gate(0, 1'b0, 1'b0);
      tick();
      set_gate(0, 1'b1, 1'b1);
      tick();
    end
    p14 = 1'b1;
    tick();
    checks++;
    if (cnt !== (STATS ? 16'd5 : 16'd0)) begin
      errors++;
      $display("FAIL unpowered_count got %h want %h", cnt, (STATS ? 16'd5 : 16'd0));
    end
  endtask

  task automatic test_reset_mid;
    cnt_sel = 2'd0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (cnt !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_cnt got %h want 0000", cnt);
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_saturate;
    cnt_sel = 2'd0;
    set_gate(0, 1'b1, 1'b1);
    tick();
    tick();
`ifdef SN7402_STATS_EN
    force dut.cnt_a_q = 16'hFFFF;
    #1;
    release dut.cnt_a_q;
    #1;
`endif
    for (int i = 0; i < 2; i++) begin
      set_gate(0, 1'b0, 1'b0);
      tick();
      checks++;
      if (cnt !== (STATS ? 16'hFFFF : 16'h0000)) begin
        errors++;
        $display("FAIL saturate_%0d got %h want %h", i, cnt, (STATS ? 16'hFFFF : 16'h0000));
      end
      set_gate(0, 1'b1, 1'b1);
      tick();
    end
  endtask

  initial begin
    logic probe;
    probe = 1'bx;
    four_state = (probe === 1'bx);
    p2 = 1'b1; p3 = 1'b1; p5 = 1'b1; p6 = 1'b1;
    p8 = 1'b1; p9 = 1'b1; p11 = 1'b1; p12 = 1'b1;
    p7 = 1'b0; p14 = 1'b1; cnt_sel = 2'd0;
    rst = 1'b1;
    #2;
    test_reset();
    rst = 1'b0;
    #1;
    test_truth();
    test_xprop();
    test_supply();
    test_armed();
    test_count();
    test_no_count_unpowered();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sn7402.md
SN7402 -- requirements
Module: sn7402

Interface
REQ-001 The port list SHALL be, in positional order, P1..P14 followed by clk, rst, cnt_sel, cnt, pwr_fault, so 14-pin positional instantiations stay valid.
REQ-002 Port: clk  input  1  free-running diagnostic clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Ports: P2, P3, P5, P6, P8, P9, P11, P12  input  1 each  gate inputs: gate A = P2/P3, gate B = P5/P6, gate C = P8/P9, gate D = P11/P12.
REQ-005 Ports: P1, P4, P10, P13  output  1 each  gate outputs: A -> P1, B -> P4, C -> P10, D -> P13.
REQ-006 Port: P7  input  1  GND pin; valid supply requires P7 = 0.
REQ-007 Port: P14  input  1  VCC pin; valid supply requires P14 = 1.
REQ-008 Port: cnt_sel  input  2  selects the counter on cnt: 0 = A, 1 = B, 2 = C, 3 = D.
REQ-009 Port: cnt  output  16  rising-edge count of the selected gate output.
REQ-010 Port: pwr_fault  output  1  registered supply-fault flag.

Function
REQ-011 With a valid supply, each gate output SHALL be the combinational NOR of its two inputs, with zero delay and no dependence on clk: 00 -> 1; 01, 10 and 11 -> 0.
REQ-012 With a valid supply, any input = 1 SHALL force the gate output to 0 even if the other input is X or Z; otherwise X/Z on an input SHALL give X on the output.
REQ-013 If P14 !== 1 or P7 !== 0, all four gate outputs SHALL be high-impedance (Z).
REQ-014 pwr_fault SHALL be set on each rising clk edge where the supply is invalid, and cleared on each rising clk edge where it is valid.
REQ-015 Each gate SHALL have a 16-bit counter that increments by 1 on a rising clk edge where the registered previous output was 0 and the current output is 1.
REQ-016 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-017 Each gate SHALL keep a previous-output register that samples its output on every rising clk edge; a Z or X sample SHALL be stored as 0.
REQ-018 An armed bit SHALL be cleared by reset and set on the first rising clk edge after reset; no counter SHALL increment on that first edge.
REQ-019 cnt SHALL be a combinational mux of the four counters by cnt_sel; a cnt_sel change SHALL be reflected with zero latency.
REQ-020 No counter SHALL increment while the supply is invalid.

Reset
REQ-021 While rst = 1, asynchronously: all counters = 0, all previous-output registers = 0, armed = 0, pwr_fault = 0.
REQ-022 Gate outputs P1/P4/P10/P13 SHALL be unaffected by rst and SHALL stay purely combinational at all times.
REQ-023 Asserting rst mid-operation SHALL discard counts immediately; counting SHALL resume per REQ-018 after rst is deasserted.

Configuration
REQ-024 Macro SN7402_STATS_EN: when defined, the counters, previous-output registers, armed bit, cnt_sel and cnt logic (REQ-015..REQ-020) SHALL be compiled in.
REQ-025 When SN7402_STATS_EN is undefined, the cnt port SHALL remain present and be driven to 16'h0000, and cnt_sel SHALL be ignored.
REQ-026 The gate logic and pwr_fault SHALL be present in both configurations.

Verification
REQ-027 P14 = 1, P7 = 0; drive each gate's inputs in the sequence 00, 01, 10, 11 with #1 between steps, one gate at a time -> that output reads 1, 0, 0, 0 respectively.
REQ-028 Supply valid, P2 = 1, P3 = X -> P1 = 0; then P2 = 0, P3 = X -> P1 = X.
REQ-029 Set P14 = 0 -> P1, P4, P10 and P13 all read Z immediately, and pwr_fault = 1 after the next rising clk edge; restore P14 = 1 -> pwr_fault = 0 after the next edge.
REQ-030 SN7402_STATS_EN defined: reset, then toggle P2/P3 between 11 and 00 five times with clk edges between each change, cnt_sel = 0 -> cnt = 5; cnt_sel = 1 -> cnt = 0.
REQ-031 Assert rst mid-count -> cnt = 0 immediately; force counter A to 16'hFFFF, then apply one more rising edge -> cnt stays at 16'hFFFF.
